// File: rtl/ccff_loader_if.sv
// ccff_loader_if: valid/ready word stream feeding the configuration loader.
//   s_data  - configuration word, bit 0 is shifted onto the chain first
//   s_valid - s_data holds a word
//   s_ready - loader takes the word this cycle
// Modports: master (word source), slave (loader).
interface ccff_loader_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_loader.sv
// ccff_loader: sequences the fabric configuration chain. Words taken over the
// src stream are serialised LSB-first onto ccff_head, one bit per cycle with
// ccff_shift_en high, until BITSTREAM_SIZE bits have been shifted.
// Optional pre-load chain-length check, enabled by CCFF_LOADER_CHAIN_CHECK_EN:
// flush the chain with zeros, send one marker bit and expect it on ccff_tail
// after exactly BITSTREAM_SIZE shifts.
// Ports:
//   prog_clk, prog_reset - clock, asynchronous active-high reset
//   start                - single-cycle load request, honoured only when idle
//   src                  - word stream (slave side)
//   ccff_head            - registered serial bit to the chain head
//   ccff_shift_en        - registered chain clock-enable
//   ccff_tail            - chain tail output
//   busy                 - sequence in progress
//   done, error          - sticky status, cleared by start
//   err_code             - 0 none, 1 tail early, 2 tail late/missing
module ccff_loader #(
    parameter int BITSTREAM_SIZE = 29696,
    parameter int DATA_W         = 32
) (
    input  logic             prog_clk,
    input  logic             prog_reset,
    input  logic             start,
    ccff_loader_if.slave     src,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    input  logic             ccff_tail,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);
    localparam int NumWords = BITSTREAM_SIZE / DATA_W;
    localparam int CntW     = $clog2(BITSTREAM_SIZE + 2);
    localparam int WordCntW = $clog2(NumWords + 1);
    localparam int SrCntW   = $clog2(DATA_W + 1);

    localparam logic [CntW-1:0]     LastBit  = CntW'(BITSTREAM_SIZE - 1);
    localparam logic [CntW-1:0]     ChainLen = CntW'(BITSTREAM_SIZE);
    localparam logic [CntW-1:0]     CntMax   = CntW'(BITSTREAM_SIZE + 1);
    localparam logic [WordCntW-1:0] WordsAll = WordCntW'(NumWords);
    localparam logic [SrCntW-1:0]   SrRefill = SrCntW'(DATA_W - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFlush = 3'd1;
    localparam logic [2:0] StMark  = 3'd2;
    localparam logic [2:0] StLoad  = 3'd3;
    localparam logic [2:0] StFin   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [SrCntW-1:0]   sr_cnt_q, sr_cnt_d;   // bits still waiting in sr_q
    logic [WordCntW-1:0] words_q, words_d;
    logic                head_q, head_d;
    logic                shift_en_q, shift_en_d;
    logic                done_q, done_d;
    logic                accept;

`ifdef CCFF_LOADER_CHAIN_CHECK_EN
    logic       error_q, error_d;
    logic [1:0] err_code_q, err_code_d;
`endif

    // sr_cnt_q == 0 covers both "empty" and "head shows the last bit", so a word
    // taken on the last-bit cycle follows without a bubble.
    assign src.s_ready = (state_q == StLoad) && (sr_cnt_q == '0) && (words_q != WordsAll);
    assign accept      = src.s_valid && src.s_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        sr_cnt_d   = sr_cnt_q;
        words_d    = words_q;
        head_d     = head_q;
        shift_en_d = shift_en_q;
        done_d     = done_q;
`ifdef CCFF_LOADER_CHAIN_CHECK_EN
        error_d    = error_q;
        err_code_d = err_code_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    done_d   = 1'b0;
                    cnt_d    = '0;
                    sr_d     = '0;
                    sr_cnt_d = '0;
                    words_d  = '0;
                    head_d   = 1'b0;
`ifdef CCFF_LOADER_CHAIN_CHECK_EN
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                    state_d    = StFlush;
                    shift_en_d = 1'b1;
`else
                    state_d    = StLoad;
                    shift_en_d = 1'b0;
`endif
                end
            end
`ifdef CCFF_LOADER_CHAIN_CHECK_EN
            StFlush: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    state_d = StMark;
                    head_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            StMark: begin
                head_d = 1'b0;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (ccff_tail) begin
                    if (cnt_q == ChainLen) begin
                        state_d    = StLoad;
                        shift_en_d = 1'b0;
                        cnt_d      = '0;
                    end else begin
                        state_d    = StIdle;
                        shift_en_d = 1'b0;
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                    end
                end else if (cnt_q >= ChainLen) begin
                    // This edge completes shift BITSTREAM_SIZE+1 with no marker seen.
                    state_d    = StIdle;
                    shift_en_d = 1'b0;
                    error_d    = 1'b1;
                    err_code_d = 2'd2;
                end
            end
`endif
            StLoad: begin
                if (shift_en_q && (cnt_q != CntMax)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (sr_cnt_q != '0) begin
                    head_d     = sr_q[0];
                    sr_d       = sr_q >> 1;
                    sr_cnt_d   = sr_cnt_q - 1'b1;
                    shift_en_d = 1'b1;
                end else if (accept) begin
                    head_d     = src.s_data[0];
                    sr_d       = src.s_data >> 1;
                    sr_cnt_d   = SrRefill;
                    words_d    = words_q + 1'b1;
                    shift_en_d = 1'b1;
                end else begin
                    // Starved: head holds, chain does not move.
                    shift_en_d = 1'b0;
                end
                if (shift_en_q && (cnt_q == LastBit)) begin
                    state_d    = StFin;
                    shift_en_d = 1'b0;
                end
            end
            StFin: begin
                state_d    = StIdle;
                shift_en_d = 1'b0;
                done_d     = 1'b1;
            end
            default: begin
                state_d    = StIdle;
                shift_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sr_q       <= '0;
            sr_cnt_q   <= '0;
            words_q    <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            sr_cnt_q   <= sr_cnt_d;
            words_q    <= words_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            done_q     <= done_d;
        end
    end

`ifdef CCFF_LOADER_CHAIN_CHECK_EN
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign error    = error_q;
    assign err_code = err_code_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign error       = 1'b0;
    assign err_code    = 2'd0;
`endif

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader with a 64-bit chain and 8-bit words.
// A behavioural chain model shifts ccff_head in on every enabled edge; the
// chain length (64/63) and a stuck-at-0 tail are selectable.
module tb_ccff_loader;
    localparam int N = 64;
    localparam int W = 8;
`ifdef CCFF_LOADER_CHAIN_CHECK_EN
    localparam int PreShifts = 129;   // 64 flush + 65 marker-phase shifts
`else
    localparam int PreShifts = 0;
`endif
    localparam int BaseCycles = 66 + ((PreShifts != 0) ? 129 : 0);

    logic       prog_clk;
    logic       prog_reset;
    logic       start;
    logic       ccff_head;
    logic       ccff_shift_en;
    logic       ccff_tail;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    ccff_loader_if #(.DATA_W(W)) src_if ();

    ccff_loader #(.BITSTREAM_SIZE(N), .DATA_W(W)) dut (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start),
        .src          (src_if),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Chain model and event counters.
    logic [63:0] chain = '0;
    int          shift_cnt = 0;
    int          hs_idx = 0;
    bit          short_chain = 1'b0;
    bit          stuck = 1'b0;

    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain     <= {chain[62:0], ccff_head};
            shift_cnt <= shift_cnt + 1;
        end
        if (src_if.s_valid && src_if.s_ready) hs_idx <= hs_idx + 1;
    end

    always_comb ccff_tail = stuck ? 1'b0 : (short_chain ? chain[62] : chain[63]);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " head"}, 64'(ccff_head), 64'd0);
        chk({tag, " shift_en"}, 64'(ccff_shift_en), 64'd0);
        chk({tag, " s_ready"}, 64'(src_if.s_ready), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " error"}, 64'(error), 64'd0);
        chk({tag, " err_code"}, 64'(err_code), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one load; stops early once rst_at shifts have happened (rst_at >= 0).
    task automatic do_load(input logic [63:0] wds, input int v_on, input int v_off,
                           input int rst_at, output int cycles, output int shifts,
                           output int words);
        int base_hs;
        int base_sh;
        int widx;
        base_hs = hs_idx;
        base_sh = shift_cnt;
        cycles  = 0;
        pulse_start();
        while (!done && cycles < 2000) begin
            widx = hs_idx - base_hs;
            src_if.s_data  = (widx < 8) ? wds[8*widx +: 8] : 8'h00;
            src_if.s_valid = (widx < 8) && ((v_off == 0) || ((cycles % (v_on + v_off)) < v_on));
            @(posedge prog_clk);
            #1;
            cycles++;
            if (rst_at >= 0 && (shift_cnt - base_sh) == rst_at) break;
        end
        src_if.s_valid = 1'b0;
        shifts = shift_cnt - base_sh;
        words  = hs_idx - base_hs;
    endtask

    typedef struct {
        string       name;
        logic [63:0] words;
        int          v_on;
        int          v_off;
        int          exp_cycles;   // -1: not checked
        logic [63:0] exp_chain;
    } vec_t;

    localparam logic [63:0] WordsA = 64'h7E81F00FC35A3CA5;   // A5,3C,5A,C3,0F,F0,81,7E
    localparam logic [63:0] ChainA = 64'hA53C5AC3F00F817E;
    localparam logic [63:0] WordsB = 64'h0807060504030201;   // 01..08
    localparam logic [63:0] ChainB = 64'h8040C020A060E010;

    vec_t vecs[4];

    int cycles;
    int shifts;
    int words;

    initial begin
        vecs[0] = '{"gapless_a", WordsA, 1, 0, BaseCycles, ChainA};
        vecs[1] = '{"gapless_b", WordsB, 1, 0, BaseCycles, ChainB};
        vecs[2] = '{"starve_a", WordsA, 3, 3, -1, ChainA};
        vecs[3] = '{"starve_b", WordsB, 2, 1, -1, ChainB};

        prog_reset     = 1'b1;
        start          = 1'b0;
        src_if.s_data  = '0;
        src_if.s_valid = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        chk_reset_vals("reset");
        prog_reset = 1'b0;
        @(posedge prog_clk);
        #1;

`ifdef CCFF_LOADER_CHAIN_CHECK_EN
        // Correct chain: marker reaches tail after 64 marker shifts, then LOAD.
        pulse_start();
        chk("chk_pass busy", 64'(busy), 64'd1);
        cycles = 0;
        while (!ccff_tail && cycles < 500) begin
            @(posedge prog_clk);
            #1;
            cycles++;
        end
        chk("chk_pass tail cycle", 64'(cycles), 64'd128);
        @(posedge prog_clk);
        #1;
        chk("chk_pass s_ready", 64'(src_if.s_ready), 64'd1);
        chk("chk_pass shift_en", 64'(ccff_shift_en), 64'd0);
        chk("chk_pass error", 64'(error), 64'd0);
        prog_reset = 1'b1;
        #1;
        chk_reset_vals("chk_pass reset");
        @(negedge prog_clk);
        prog_reset = 1'b0;
        @(posedge prog_clk);
        #1;

        // Short (63-bit) chain, then stuck-at-0 tail.
        for (int f = 0; f < 2; f++) begin
            short_chain = (f == 0);
            stuck       = (f == 1);
            shifts      = shift_cnt;
            pulse_start();
            cycles = 0;
            while (!error && cycles < 500) begin
                @(posedge prog_clk);
                #1;
                cycles++;
            end
            shifts = shift_cnt - shifts;
            chk(f == 0 ? "short err_code" : "broken err_code", 64'(err_code),
                (f == 0) ? 64'd1 : 64'd2);
            chk(f == 0 ? "short cycles" : "broken cycles", 64'(cycles),
                (f == 0) ? 64'd128 : 64'd129);
            chk(f == 0 ? "short shift_en" : "broken shift_en", 64'(ccff_shift_en), 64'd0);
            chk(f == 0 ? "short busy" : "broken busy", 64'(busy), 64'd0);
            if (f == 1) chk("broken shifts", 64'(shifts), 64'd129);
        end
        short_chain = 1'b0;
        stuck       = 1'b0;
`endif

        for (int i = 0; i < 4; i++) begin
            do_load(vecs[i].words, vecs[i].v_on, vecs[i].v_off, -1, cycles, shifts, words);
            chk({vecs[i].name, " done"}, 64'(done), 64'd1);
            if (vecs[i].exp_cycles >= 0)
                chk({vecs[i].name, " cycles"}, 64'(cycles), 64'(vecs[i].exp_cycles));
            chk({vecs[i].name, " chain"}, chain, vecs[i].exp_chain);
            chk({vecs[i].name, " shifts"}, 64'(shifts), 64'(N + PreShifts));
            chk({vecs[i].name, " words"}, 64'(words), 64'd8);
            chk({vecs[i].name, " busy"}, 64'(busy), 64'd0);
            chk({vecs[i].name, " error"}, 64'(error), 64'd0);
            @(posedge prog_clk);
            #1;
            chk({vecs[i].name, " done sticky"}, 64'(done), 64'd1);
        end

        // Mid-load reset at bit 20, then a full reload of different data.
        do_load(WordsA, 1, 0, 20 + PreShifts, cycles, shifts, words);
        chk("midrst reached bit 20", 64'(shifts), 64'(20 + PreShifts));
        prog_reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge prog_clk);
        prog_reset = 1'b0;
        @(posedge prog_clk);
        #1;
        chk("midrst done after release", 64'(done), 64'd0);
        do_load(WordsB, 1, 0, -1, cycles, shifts, words);
        chk("reload done", 64'(done), 64'd1);
        chk("reload cycles", 64'(cycles), 64'(BaseCycles));
        chk("reload chain", chain, ChainB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
